// File: rtl/rob_rollback_ctrl_if.sv
// rob_rollback_ctrl_if: branch-report, retire and recovery signals between the ROB, branch FUs and rollback controller
interface rob_rollback_ctrl_if #(
    parameter int NUM_ROB = 32,
    parameter int NUM_REQ = 2,
    parameter int PC_W    = 64
);
    localparam int IDX_W = $clog2(NUM_ROB);
    logic [NUM_REQ-1:0]       br_valid;
    logic [NUM_REQ*IDX_W-1:0] br_rob_idx;
    logic [NUM_REQ*PC_W-1:0]  br_target;
    logic [IDX_W-1:0]         rob_head;
    logic [1:0]               retire_en;
    logic                     rollback_en;
    logic [IDX_W-1:0]         rollback_idx;
    logic                     redirect_valid;
    logic [PC_W-1:0]          redirect_pc;
    logic                     stall_dispatch;
    logic                     busy;
    logic [15:0]              drop_cnt;
    modport slave (
        input  br_valid, br_rob_idx, br_target, rob_head, retire_en,
        output rollback_en, rollback_idx, redirect_valid, redirect_pc, stall_dispatch, busy, drop_cnt
    );
    modport master (
        output br_valid, br_rob_idx, br_target, rob_head, retire_en,
        input  rollback_en, rollback_idx, redirect_valid, redirect_pc, stall_dispatch, busy, drop_cnt
    );
endinterface

// File: rtl/rob_rollback_ctrl.sv
// rob_rollback_ctrl: picks the oldest branch mispredict, issues one rollback/redirect pulse
// and stalls dispatch until that branch retires.
module rob_rollback_ctrl #(
    parameter int NUM_ROB = 32,
    parameter int NUM_REQ = 2,
    parameter int PC_W    = 64
) (
    input logic           clock,
    input logic           reset,
    input logic           en,
    rob_rollback_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_ROB);
    localparam int LANE_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(NUM_REQ + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  pend_idx, pend_age, win_idx, head_p1;
    logic [PC_W-1:0]   pend_pc, win_pc;
    logic [15:0]       drop_cnt, drop_n;
    logic [16:0]       drop_sum;
    logic [IDX_W-1:0]  age [NUM_REQ];
    logic [LANE_W-1:0] win_lane;
    logic [CNT_W-1:0]  n_valid;
    logic              found, exit_ok, idle_eff, load, discard;

    genvar k;
    for (k = 0; k < NUM_REQ; k = k + 1) begin : g_age
        assign age[k] = bus.br_rob_idx[k*IDX_W +: IDX_W] - bus.rob_head;
    end

    // Strict compare while scanning upward keeps the lowest lane on equal age.
    always_comb begin
        win_lane = '0;
        found    = 1'b0;
        n_valid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.br_valid[i]) begin
                n_valid = n_valid + CNT_W'(1);
                if (!found || age[i] < age[win_lane]) win_lane = LANE_W'(i);
                found = 1'b1;
            end
        end
    end

    assign win_idx  = bus.br_rob_idx[win_lane*IDX_W +: IDX_W];
    assign win_pc   = bus.br_target[win_lane*PC_W +: PC_W];
    assign pend_age = pend_idx - bus.rob_head;
    assign head_p1  = bus.rob_head + IDX_W'(1);

    // A retiring branch frees the controller first, so a same-cycle report is taken as if in IDLE.
    always_comb begin
        exit_ok  = state == RECOVER &&
                   ((bus.retire_en[0] && bus.rob_head == pend_idx) || (bus.retire_en[1] && head_p1 == pend_idx));
        idle_eff = state == IDLE || exit_ok;
        load     = found && (idle_eff || age[win_lane] < pend_age);
        discard  = found && !load;
        state_n  = load ? FLUSH : idle_eff ? IDLE : RECOVER;
        drop_sum = {1'b0, drop_cnt} + 17'(n_valid) + 17'(discard) - 17'(found);
        drop_n   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pend_idx <= '0;
            pend_pc  <= '0;
            drop_cnt <= '0;
        end else if (en) begin
            state    <= state_n;
            drop_cnt <= drop_n;
            if (load) begin
                pend_idx <= win_idx;
                pend_pc  <= win_pc;
            end
        end
    end

    assign bus.rollback_en    = en && state == FLUSH;
    assign bus.redirect_valid = en && state == FLUSH;
    assign bus.rollback_idx   = pend_idx;
    assign bus.redirect_pc    = pend_pc;
    assign bus.stall_dispatch = state != IDLE;
    assign bus.busy           = state != IDLE;
    assign bus.drop_cnt       = drop_cnt;
endmodule

// File: tb/tb_rob_rollback_ctrl.sv
// tb_rob_rollback_ctrl: directed and randomized checks of rob_rollback_ctrl against a cycle-level recovery model
module tb_rob_rollback_ctrl;
    localparam int N = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b1;
    logic [4:0]  li [2];
    logic [63:0] lp [2];

    rob_rollback_ctrl_if #(.NUM_ROB(N), .NUM_REQ(2), .PC_W(64)) bus ();
    rob_rollback_ctrl #(.NUM_ROB(N), .NUM_REQ(2), .PC_W(64)) dut (
        .clock(clock), .reset(reset), .en(en), .bus(bus)
    );

    assign bus.br_rob_idx = {li[1], li[0]};
    assign bus.br_target  = {lp[1], lp[0]};

    always #5 clock = ~clock;

    // Model: m_act = recovery in progress, m_owe = rollback pulse still owed.
    bit          m_act, m_owe;
    int          m_idx, m_drop;
    logic [63:0] m_pc;
    int          n_chk, n_fail, pulses;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int age(input int x, input int h);
        return (x - h + N) % N;
    endfunction

    task automatic m_reset();
        m_act = 0; m_owe = 0; m_idx = 0; m_pc = '0; m_drop = 0;
    endtask

    task automatic model_edge();
        int w, nv, h;
        bit ret;
        if (!en) return;
        w  = -1;
        nv = 0;
        h  = int'(bus.rob_head);
        for (int l = 0; l < 2; l++)
            if (bus.br_valid[l]) begin
                nv++;
                if (w < 0 || age(int'(li[l]), h) < age(int'(li[w]), h)) w = l;
            end
        ret = m_act && !m_owe &&
              ((bus.retire_en[0] && h == m_idx) || (bus.retire_en[1] && (h + 1) % N == m_idx));
        if (ret) m_act = 0;
        if (w >= 0 && (!m_act || age(int'(li[w]), h) < age(m_idx, h))) begin
            m_act = 1; m_owe = 1; m_idx = int'(li[w]); m_pc = lp[w];
        end else begin
            m_owe = 0;
            if (w >= 0) m_drop++;
        end
        if (nv > 1) m_drop += nv - 1;
        if (m_drop > 65535) m_drop = 65535;
    endtask

    task automatic cmp();
        bit p;
        p = m_owe && en;
        if (bus.rollback_en) pulses++;
        chk("rollback_en", bus.rollback_en, p);
        chk("redirect_valid", bus.redirect_valid, p);
        chk("stall_dispatch", bus.stall_dispatch, m_act);
        chk("busy", bus.busy, m_act);
        chk("drop_cnt", bus.drop_cnt, m_drop);
        if (p) begin
            chk("rollback_idx", bus.rollback_idx, m_idx);
            chk("redirect_pc", bus.redirect_pc, m_pc);
        end
    endtask

    task automatic step(input bit c = 1'b1);
        @(negedge clock);
        if (c) cmp();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic put(input logic [1:0] v, input int i0, input int i1, input int h, input logic [1:0] r,
                       input logic [63:0] pc0 = '0, input bit c = 1'b1);
        bus.br_valid  = v;
        li[0]         = 5'(i0);
        li[1]         = 5'(i1);
        lp[0]         = pc0;
        lp[1]         = {$urandom, $urandom};
        bus.rob_head  = 5'(h);
        bus.retire_en = r;
        step(c);
    endtask

    initial begin
        bus.br_valid = '0; bus.rob_head = '0; bus.retire_en = '0;
        li[0] = '0; li[1] = '0; lp[0] = '0; lp[1] = '0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        cmp();
        chk("rst_idx", bus.rollback_idx, 0);
        chk("rst_pc", bus.redirect_pc, 0);
        reset = 1'b1;

        put(2'b01, 9, 0, 4, 2'b00, 64'h1000);
        chk("t1_en", bus.rollback_en, 1);
        chk("t1_idx", bus.rollback_idx, 9);
        chk("t1_pc", bus.redirect_pc, 64'h1000);
        put(2'b00, 0, 0, 4, 2'b00);
        put(2'b00, 0, 0, 4, 2'b01);
        chk("t1_stall", bus.stall_dispatch, 1);
        put(2'b00, 0, 0, 9, 2'b01);
        chk("t1_idle", bus.busy, 0);

        put(2'b11, 2, 31, 30, 2'b00, 64'h2222);
        chk("t2_idx", bus.rollback_idx, 31);
        chk("t2_drop", bus.drop_cnt, 1);
        put(2'b00, 0, 0, 30, 2'b00);
        put(2'b00, 0, 0, 31, 2'b01);

        put(2'b01, 10, 0, 5, 2'b00, 64'h3000);
        put(2'b00, 0, 0, 5, 2'b00);
        put(2'b10, 0, 7, 5, 2'b00);
        chk("t3_pre_en", bus.rollback_en, 1);
        chk("t3_pre_idx", bus.rollback_idx, 7);
        put(2'b00, 0, 0, 5, 2'b00);
        put(2'b01, 12, 0, 5, 2'b00, 64'h3333);
        chk("t3_drop_en", bus.rollback_en, 0);
        chk("t3_drop", bus.drop_cnt, 2);
        put(2'b00, 0, 0, 7, 2'b01);

        put(2'b01, 9, 0, 8, 2'b00, 64'h4000);
        put(2'b00, 0, 0, 8, 2'b00);
        put(2'b00, 0, 0, 8, 2'b11);
        chk("t4_exit", bus.busy, 0);
        put(2'b01, 9, 0, 8, 2'b00, 64'h4000);
        put(2'b00, 0, 0, 8, 2'b00);
        put(2'b00, 0, 0, 8, 2'b01);
        chk("t4_hold", bus.busy, 1);

        #2 reset = 1'b0;
        #1;
        chk("t5_en", bus.rollback_en, 0);
        chk("t5_stall", bus.stall_dispatch, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_drop", bus.drop_cnt, 0);
        chk("t5_idx", bus.rollback_idx, 0);
        chk("t5_pc", bus.redirect_pc, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        m_reset();
        pulses = 0;
        repeat (3) put(2'b00, 0, 0, $urandom_range(N - 1), 2'($urandom_range(3)));
        chk("t5_nopulse", pulses, 0);

        put(2'b01, 3, 0, 0, 2'b00, 64'hDEAD);
        en = 1'b0;
        pulses = 0;
        repeat (3) put(2'b11, 1, 2, 0, 2'b00);
        chk("t6_drop_hold", bus.drop_cnt, 0);
        en = 1'b1;
        put(2'b00, 0, 0, 0, 2'b00);
        put(2'b00, 0, 0, 0, 2'b00);
        chk("t6_pulses", pulses, 1);
        put(2'b00, 0, 0, 3, 2'b01);

        put(2'b11, 6, 6, 0, 2'b00, 64'hAAAA);
        chk("tie_pc", bus.redirect_pc, 64'hAAAA);
        put(2'b00, 0, 0, 6, 2'b01);
        put(2'b00, 0, 0, 6, 2'b01);

        put(2'b01, 0, 0, 31, 2'b00, 64'h5000);
        put(2'b00, 0, 0, 31, 2'b00);
        put(2'b00, 0, 0, 31, 2'b10);
        chk("wrap_exit", bus.busy, 0);

        repeat (3000) begin
            int h;
            logic [1:0] v;
            en = ($urandom_range(9) != 0);
            h  = ($urandom_range(2) == 0) ? (m_idx + N - int'($urandom_range(1))) % N : int'($urandom_range(N - 1));
            v  = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            put(v, $urandom_range(N - 1), $urandom_range(N - 1), h, 2'($urandom_range(3)), {$urandom, $urandom});
        end

        en = 1'b1;
        put(2'b01, 20, 0, 20, 2'b00, 64'h6000);
        put(2'b00, 0, 0, 20, 2'b00);
        for (int i = 0; i < 33000; i++)
            put(2'b11, $urandom_range(N - 1), $urandom_range(N - 1), 20, 2'b00, {$urandom, $urandom}, i % 4096 == 0);
        chk("sat_drop", bus.drop_cnt, 16'hFFFF);
        chk("sat_busy", bus.busy, 1);
        repeat (4) put(2'b11, $urandom_range(N - 1), $urandom_range(N - 1), 20, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
